// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - Requester/register-bank bus for reg_write_arbiter; Lock present only with REG_ARB_LOCK_EN.
interface reg_write_arbiter_if #(
  parameter int N    = 16,
  parameter int NREG = 8
);
  localparam int A = (NREG > 1) ? $clog2(NREG) : 1;

  logic [3:0]      Req;
  logic [4*A-1:0]  Addr_In;
  logic [4*N-1:0]  Data_In;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]      Lock;
`endif
  logic [3:0]      Ack;
  logic [NREG-1:0] Load_Out;
  logic [N-1:0]    Data_Out;
  logic [1:0]      Grant_Id;
  logic            Busy;

`ifdef REG_ARB_LOCK_EN
  modport master (
    output Req, Addr_In, Data_In, Lock,
    input  Ack, Load_Out, Data_Out, Grant_Id, Busy
  );
  modport slave (
    input  Req, Addr_In, Data_In, Lock,
    output Ack, Load_Out, Data_Out, Grant_Id, Busy
  );
`else
  modport master (
    output Req, Addr_In, Data_In,
    input  Ack, Load_Out, Data_Out, Grant_Id, Busy
  );
  modport slave (
    input  Req, Addr_In, Data_In,
    output Ack, Load_Out, Data_Out, Grant_Id, Busy
  );
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - Four-requester round-robin register write arbiter; REG_ARB_LOCK_EN adds Lock/LOCKED.
module reg_write_arbiter #(
  parameter int N    = 16,
  parameter int NREG = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  reg_write_arbiter_if.slave bus
);
  localparam int A = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef REG_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} state_t;
`else
  typedef enum logic {IDLE, ISSUE} state_t;
`endif

  state_t          state, state_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [3:0]      ack_q, ack_nxt;
  logic [NREG-1:0] load_q, load_nxt;
  logic [N-1:0]    data_q, data_nxt;
  logic [1:0]      gid_q, gid_nxt;

  logic [3:0]      eligible;
  logic            win_vld;
  logic [1:0]      win;
  logic            sel_vld;
  logic [1:0]      sel;
  logic [A-1:0]    sel_addr;

  // A requester being acknowledged this cycle still shows Req; masking it prevents a double write.
  assign eligible = bus.Req & ~ack_q;

  always_comb begin : rr_pick
    win_vld = 1'b0;
    win     = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[ptr + 2'(k)]) begin
        win_vld = 1'b1;
        win     = ptr + 2'(k);
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  logic lock_hold;
  assign lock_hold = (state == LOCKED) && bus.Req[gid_q] && bus.Lock[gid_q];
`endif

  always_comb begin : next_state
    sel_vld   = win_vld;
    sel       = win;
`ifdef REG_ARB_LOCK_EN
    if (lock_hold) begin
      sel_vld = 1'b1;
      sel     = gid_q;
    end
`endif
    sel_addr  = bus.Addr_In[int'(sel)*A +: A];
    state_nxt = IDLE;
    ptr_nxt   = ptr;
    ack_nxt   = '0;
    load_nxt  = '0;
    data_nxt  = '0;
    gid_nxt   = '0;
    if (sel_vld) begin
      state_nxt = ISSUE;
`ifdef REG_ARB_LOCK_EN
      if (bus.Lock[sel]) state_nxt = LOCKED;
`endif
      ptr_nxt      = sel + 2'd1;
      ack_nxt[sel] = 1'b1;
      // Out-of-range addresses match no slot, so the write is acknowledged but discarded.
      for (int r = 0; r < NREG; r++) begin
        load_nxt[r] = (sel_addr == A'(r));
      end
      data_nxt = bus.Data_In[int'(sel)*N +: N];
      gid_nxt  = sel;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      ack_q  <= '0;
      load_q <= '0;
      data_q <= '0;
      gid_q  <= 2'd0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      ack_q  <= ack_nxt;
      load_q <= load_nxt;
      data_q <= data_nxt;
      gid_q  <= gid_nxt;
    end
  end

  assign bus.Ack      = ack_q;
  assign bus.Load_Out = load_q;
  assign bus.Data_Out = data_q;
  assign bus.Grant_Id = gid_q;
  assign bus.Busy     = (state != IDLE);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - Directed-vector bench for reg_write_arbiter (lock vectors when REG_ARB_LOCK_EN is defined).
module tb_reg_write_arbiter;
  logic Clk;
  logic Reset_n;
  int   checks   = 0;
  int   failures = 0;

  reg_write_arbiter_if #(.N(16), .NREG(8)) bus ();
  reg_write_arbiter_if #(.N(16), .NREG(6)) bus6 ();

  reg_write_arbiter #(.N(16), .NREG(8)) u_dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  reg_write_arbiter #(.N(16), .NREG(6)) u_dut6 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus6)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},  bus.Ack,      32'h0);
    chk({tag, "_load"}, bus.Load_Out, 32'h0);
    chk({tag, "_data"}, bus.Data_Out, 32'h0);
    chk({tag, "_gid"},  bus.Grant_Id, 32'h0);
    chk({tag, "_busy"}, bus.Busy,     32'h0);
  endtask

  initial begin
    int g;
    Reset_n      = 1'b1;
    bus.Req      = '0;
    bus.Addr_In  = '0;
    bus.Data_In  = '0;
    bus6.Req     = '0;
    bus6.Addr_In = '0;
    bus6.Data_In = '0;
`ifdef REG_ARB_LOCK_EN
    bus.Lock     = '0;
    bus6.Lock    = '0;
`endif
    #2 Reset_n = 1'b0;
    #1 chk_idle("reset");
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Single uncontested write, one-cycle latency
    bus.Req               = 4'b0001;
    bus.Addr_In[2:0]      = 3'd3;
    bus.Data_In[15:0]     = 16'hBEEF;
    tick();
    chk("single_load", bus.Load_Out, 32'h08);
    chk("single_data", bus.Data_Out, 32'hBEEF);
    chk("single_ack",  bus.Ack,      32'h1);
    chk("single_gid",  bus.Grant_Id, 32'h0);
    chk("single_busy", bus.Busy,     32'h1);
    bus.Req = 4'b0000;
    tick();
    chk("single_t2_load", bus.Load_Out, 32'h0);
    chk("single_t2_busy", bus.Busy,     32'h0);

    // Req held across its Ack cycle must write only once
    bus.Req            = 4'b0010;
    bus.Addr_In[5:3]   = 3'd5;
    bus.Data_In[31:16] = 16'h1234;
    tick();
    chk("hold_ack",  bus.Ack,      32'h2);
    chk("hold_load", bus.Load_Out, 32'h20);
    chk("hold_data", bus.Data_Out, 32'h1234);
    tick();
    chk("hold_ack2",  bus.Ack,      32'h0);
    chk("hold_load2", bus.Load_Out, 32'h0);
    bus.Req = 4'b0000;
    tick();
    chk("hold_ack3", bus.Ack, 32'h0);

    // Round-robin rotation from a fresh reset
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    bus.Addr_In = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.Data_In = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    bus.Req     = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      g = c % 4;
      chk("rr_gid",  bus.Grant_Id, g);
      chk("rr_ack",  bus.Ack,      32'(1 << g));
      chk("rr_load", bus.Load_Out, 32'(1 << (g + 1)));
      chk("rr_data", bus.Data_Out, 32'hA000 + g);
    end

    // Asynchronous reset mid-stream; pointer must restart at 0
    Reset_n = 1'b0;
    #1 chk_idle("async_rst");
    @(posedge Clk);
    #1 chk_idle("rst_held");
    Reset_n = 1'b1;
    tick();
    chk("post_rst_gid", bus.Grant_Id, 32'h0);
    chk("post_rst_ack", bus.Ack,      32'h1);
    bus.Req = 4'b0000;
    tick();
    tick();
    chk("drain_busy", bus.Busy, 32'h0);

    // Out-of-range address on NREG=6 instance: acked, no load
    bus6.Req            = 4'b0100;
    bus6.Addr_In[8:6]   = 3'd6;
    bus6.Data_In[47:32] = 16'h5A5A;
    tick();
    chk("oor_ack",  bus6.Ack,      32'h4);
    chk("oor_load", bus6.Load_Out, 32'h0);
    chk("oor_busy", bus6.Busy,     32'h1);
    bus6.Req = 4'b0000;
    tick();
    bus6.Req          = 4'b0100;
    bus6.Addr_In[8:6] = 3'd5;
    tick();
    chk("edge_addr_load", bus6.Load_Out, 32'h20);
    bus6.Req = 4'b0000;
    tick();

`ifdef REG_ARB_LOCK_EN
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    bus.Req  = 4'b0011;
    bus.Lock = 4'b0010;
    tick();
    chk("lock_first_gid", bus.Grant_Id, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lock_gid", bus.Grant_Id, 32'h1);
      chk("lock_ack", bus.Ack,      32'h2);
    end
    bus.Lock = 4'b0000;
    tick();
    chk("unlock_gid", bus.Grant_Id, 32'h0);
    bus.Req = 4'b0000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
